// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the TinyRV1 memory arbiter.
package proc_mem_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_IMEM,
        GRANT_DMEM
    } grant_t;

endpackage

// File: rtl/proc_mem_arb_starve.sv
// Fetch starvation guard: counts consecutive conflicts that fetch lost,
// saturating at STARVE_MAX; tripped forces the next conflict to fetch.
module proc_mem_arb_starve
    import proc_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   imemreq_val,
    input  logic   dmemreq_val,
    input  grant_t grant,
    output logic   tripped
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX_C = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt;

    // Count lost fetch conflicts; any fetch grant or idle fetch restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_IMEM || !imemreq_val) begin
            starve_cnt <= '0;
        end else if (dmemreq_val && grant == GRANT_DMEM) begin
            if (starve_cnt != STARVE_MAX_C) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Guard trips once the run of lost conflicts reaches the limit.
    always_comb begin
        tripped = (starve_cnt == STARVE_MAX_C);
    end

endmodule

// File: rtl/proc_mem_arb.sv
// Two-requester arbiter sharing one single-ported, 1-cycle-latency memory
// between instruction fetch (imem) and load/store (dmem). Data wins conflicts.
// Optional fetch starvation guard enabled by defining PROC_MEM_ARB_STARVE_EN.
module proc_mem_arb
    import proc_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imemreq_val,
    output logic        imemreq_rdy,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    output logic [31:0] imemresp_data,

    input  logic        dmemreq_val,
    output logic        dmemreq_rdy,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    output logic [31:0] dmemresp_rdata,

    output logic        memreq_val,
    output logic        memreq_type,
    output logic [31:0] memreq_addr,
    output logic [31:0] memreq_wdata,
    input  logic [31:0] memresp_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("proc_mem_arb: STARVE_MAX must be in 1..15");
    end

    grant_t grant;
    logic   starve_tripped;
    logic   resp_imem;
    logic   resp_dmem;
    logic   resp_wr;

`ifdef PROC_MEM_ARB_STARVE_EN
    proc_mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .imemreq_val (imemreq_val),
        .dmemreq_val (dmemreq_val),
        .grant       (grant),
        .tripped     (starve_tripped)
    );
`else
    assign starve_tripped = 1'b0;
`endif

    // Pick at most one winner per cycle; nothing is granted while in reset.
    always_comb begin
        grant = GRANT_NONE;
        if (!rst) begin
            if (imemreq_val && dmemreq_val) begin
                grant = starve_tripped ? GRANT_IMEM : GRANT_DMEM;
            end else if (imemreq_val) begin
                grant = GRANT_IMEM;
            end else if (dmemreq_val) begin
                grant = GRANT_DMEM;
            end
        end
    end

    // Steer the winner's fields onto the memory port; idle bus is all zero.
    always_comb begin
        imemreq_rdy  = 1'b0;
        dmemreq_rdy  = 1'b0;
        memreq_val   = 1'b0;
        memreq_type  = MEMREQ_READ;
        memreq_addr  = '0;
        memreq_wdata = '0;
        case (grant)
            GRANT_IMEM: begin
                imemreq_rdy = 1'b1;
                memreq_val  = 1'b1;
                memreq_addr = imemreq_addr;
            end
            GRANT_DMEM: begin
                dmemreq_rdy  = 1'b1;
                memreq_val   = 1'b1;
                memreq_type  = dmemreq_type;
                memreq_addr  = dmemreq_addr;
                memreq_wdata = dmemreq_wdata;
            end
            default: ;
        endcase
    end

    // Remember who owns next cycle's memory response; reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_imem <= 1'b0;
            resp_dmem <= 1'b0;
            resp_wr   <= 1'b0;
        end else begin
            resp_imem <= (grant == GRANT_IMEM);
            resp_dmem <= (grant == GRANT_DMEM);
            resp_wr   <= (grant == GRANT_DMEM) && (dmemreq_type == MEMREQ_WRITE);
        end
    end

    // Route response data to its owner; write acks and idle ports carry zero.
    always_comb begin
        imemresp_val   = resp_imem && !rst;
        dmemresp_val   = resp_dmem && !rst;
        imemresp_data  = imemresp_val ? memresp_rdata : '0;
        dmemresp_rdata = (dmemresp_val && !resp_wr) ? memresp_rdata : '0;
    end

endmodule

// File: tb/tb_proc_mem_arb.sv
// Self-checking bench for proc_mem_arb: directed scenarios then randomized
// traffic, compared against a transaction-level model with a memory array.
module tb_proc_mem_arb;

    localparam int STARVE_MAX = 4;
`ifdef PROC_MEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_data;
    logic        dmemreq_val;
    logic        dmemreq_rdy;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic        dmemresp_val;
    logic [31:0] dmemresp_rdata;
    logic        memreq_val;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_wdata;
    logic [31:0] memresp_rdata;

    proc_mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .imemreq_val    (imemreq_val),
        .imemreq_rdy    (imemreq_rdy),
        .imemreq_addr   (imemreq_addr),
        .imemresp_val   (imemresp_val),
        .imemresp_data  (imemresp_data),
        .dmemreq_val    (dmemreq_val),
        .dmemreq_rdy    (dmemreq_rdy),
        .dmemreq_type   (dmemreq_type),
        .dmemreq_addr   (dmemreq_addr),
        .dmemreq_wdata  (dmemreq_wdata),
        .dmemresp_val   (dmemresp_val),
        .dmemresp_rdata (dmemresp_rdata),
        .memreq_val     (memreq_val),
        .memreq_type    (memreq_type),
        .memreq_addr    (memreq_addr),
        .memreq_wdata   (memreq_wdata),
        .memresp_rdata  (memresp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: memory contents, the response owed next cycle
    // (0 none, 1 fetch, 2 load, 3 store ack), and the run of lost conflicts.
    logic [31:0] mem [logic [31:0]];
    int          pend_kind = 0;
    logic [31:0] pend_data = '0;
    int          lost      = 0;
    int          last_grant = 0;
    logic        obs_irdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // One clock cycle: predict, check mid-cycle, then advance the model.
    task automatic step();
        int          g;
        logic [31:0] e_ma, e_mw, e_id, e_dd;
        logic        e_mt, e_iv, e_dv;
        if (rst)                                g = 0;
        else if (imemreq_val && dmemreq_val)    g = (STARVE_EN && lost >= STARVE_MAX) ? 1 : 2;
        else if (imemreq_val)                   g = 1;
        else if (dmemreq_val)                   g = 2;
        else                                    g = 0;
        e_ma = (g == 1) ? imemreq_addr : (g == 2) ? dmemreq_addr : 32'h0;
        e_mt = (g == 2) ? dmemreq_type : 1'b0;
        e_mw = (g == 2) ? dmemreq_wdata : 32'h0;
        e_iv = !rst && pend_kind == 1;
        e_dv = !rst && (pend_kind == 2 || pend_kind == 3);
        e_id = e_iv ? pend_data : 32'h0;
        e_dd = (!rst && pend_kind == 2) ? pend_data : 32'h0;

        @(negedge clk);
        check("imemreq_rdy",    imemreq_rdy,    (g == 1));
        check("dmemreq_rdy",    dmemreq_rdy,    (g == 2));
        check("memreq_val",     memreq_val,     (g != 0));
        check("memreq_addr",    memreq_addr,    e_ma);
        check("memreq_type",    memreq_type,    e_mt);
        check("memreq_wdata",   memreq_wdata,   e_mw);
        check("imemresp_val",   imemresp_val,   e_iv);
        check("imemresp_data",  imemresp_data,  e_id);
        check("dmemresp_val",   dmemresp_val,   e_dv);
        check("dmemresp_rdata", dmemresp_rdata, e_dd);
        obs_irdy   = imemreq_rdy;
        last_grant = g;

        @(posedge clk);
        #1;
        if (rst) begin
            pend_kind = 0;
            lost      = 0;
        end else begin
            if (g == 1) begin
                pend_kind = 1;
                pend_data = mem_rd(imemreq_addr);
            end else if (g == 2 && !dmemreq_type) begin
                pend_kind = 2;
                pend_data = mem_rd(dmemreq_addr);
            end else if (g == 2) begin
                mem[dmemreq_addr] = dmemreq_wdata;
                pend_kind = 3;
            end else begin
                pend_kind = 0;
            end
            if (imemreq_val && dmemreq_val && g == 2)
                lost = (lost + 1 > STARVE_MAX) ? STARVE_MAX : lost + 1;
            else
                lost = 0;
        end
        memresp_rdata = (pend_kind == 1 || pend_kind == 2) ? pend_data : $urandom;
    endtask

    initial begin
        int n_igrant;
        int i_cycle;
        rst = 1'b1;
        imemreq_val = 1'b0; imemreq_addr = '0;
        dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
        memresp_rdata = 32'h0;
        mem[32'h200] = 32'h00A00093;
        #1;
        step();
        step();
        rst = 1'b0;

        // Fetch only
        imemreq_val = 1'b1; imemreq_addr = 32'h200;
        step();
        imemreq_val = 1'b0;
        step();

        // Store then load
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h1000; dmemreq_wdata = 32'hDEADBEEF;
        step();
        dmemreq_type = 1'b0; dmemreq_wdata = 32'h0;
        step();
        dmemreq_val = 1'b0;
        step();

        // Conflict: data wins, fetch follows once data drops
        imemreq_val = 1'b1; imemreq_addr = 32'h200;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h1000;
        step();
        dmemreq_val = 1'b0;
        step();
        imemreq_val = 1'b0;
        step();

        // Sustained conflict for 6 cycles
        imemreq_val = 1'b1; imemreq_addr = 32'h200;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h1000;
        n_igrant = 0;
        i_cycle  = -1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (obs_irdy) begin
                n_igrant++;
                i_cycle = c;
            end
        end
        check("starve_imem_grants", n_igrant, STARVE_EN ? 1 : 0);
        check("starve_imem_cycle",  i_cycle,  STARVE_EN ? 4 : -1);
        imemreq_val = 1'b0; dmemreq_val = 1'b0;
        step();

        // Reset in the response cycle discards the pending fetch
        imemreq_val = 1'b1; imemreq_addr = 32'h200;
        step();
        imemreq_val = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();

        // Randomized traffic obeying the hold-until-ready protocol
        for (int k = 0; k < 400; k++) begin
            if (!imemreq_val && ($urandom % 2 == 0)) begin
                imemreq_val  = 1'b1;
                imemreq_addr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            end
            if (!dmemreq_val && ($urandom % 3 != 0)) begin
                dmemreq_val   = 1'b1;
                dmemreq_type  = 1'($urandom % 2);
                dmemreq_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
                dmemreq_wdata = $urandom;
            end
            rst = ($urandom % 50 == 0);
            step();
            if (last_grant == 1) imemreq_val = 1'b0;
            if (last_grant == 2) dmemreq_val = 1'b0;
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
